adc_captura_serial: RTL and testbench

Serial capture stage that sits directly downstream of the 2-bit phase counter in the ADC path. It uses the free-running counter value as a clock-divide phase and generates the ADC chip-select (cs_n) and serial clock (sclk). It shifts in one 16-bit frame (4 leading zeros plus 12 data bits, MSB first) and presents the 12-bit sample as a parallel word with a one-cycle valid strobe to the equalizer datapath.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_captura_serial.sv | 87 ++++++++
 tb/tb_adc_captura_serial.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the ADC serial capture path.
package adc_pkg;

  localparam int N_DATOS  = 12;
  localparam int N_CEROS  = 4;
  localparam int N_TRAMA  = N_CEROS + N_DATOS;
  localparam int N_ESPERA = 1;
  localparam int CNT_W    = 5;
  localparam int ESPERA_W = 4;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVIERTE = 2'd1,
    ESPERA    = 2'd2
  } estado_t;

endpackage

// File: rtl/adc_captura_serial.sv
// Serial ADC frame capture: derives cs_n/sclk from the external 2-bit phase,
// shifts in a 16-bit frame MSB first and presents the 12-bit sample with a strobe.
module adc_captura_serial
  import adc_pkg::*;
(
  input  logic               clk_reloj,
  input  logic               rst_reset,
  input  logic [1:0]         fase,
  input  logic               inicio,
  input  logic               sdata,
  output logic               cs_n,
  output logic               sclk,
  output logic [N_DATOS-1:0] dato,
  output logic               dato_valido,
  output logic               err_trama,
  output logic               ocupado
);

  localparam logic [CNT_W-1:0]    TRAMA_FIN  = CNT_W'(N_TRAMA);
  localparam logic [ESPERA_W-1:0] ESPERA_FIN = ESPERA_W'(N_ESPERA - 1);

  estado_t             estado;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ESPERA_W-1:0] espera_cnt;
  logic [N_TRAMA-1:0]  trama;

  // The ADC shifts on sclk falling edges (fase=0), so fase=1 is mid-bit.
  assign sclk    = fase[1] | cs_n;
  assign ocupado = (estado != REPOSO);

  always_ff @(posedge clk_reloj or posedge rst_reset) begin
    if (rst_reset) begin
      estado      <= REPOSO;
      cs_n        <= 1'b1;
      bit_cnt     <= '0;
      espera_cnt  <= '0;
      trama       <= '0;
      dato        <= '0;
      dato_valido <= 1'b0;
      err_trama   <= 1'b0;
    end else begin
      dato_valido <= 1'b0;
      case (estado)
        REPOSO: begin
          if (inicio && fase == 2'd3) begin
            estado  <= CONVIERTE;
            cs_n    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        CONVIERTE: begin
          if (fase == 2'd1 && bit_cnt != TRAMA_FIN) begin
            trama   <= {trama[N_TRAMA-2:0], sdata};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else if (fase == 2'd3 && bit_cnt == TRAMA_FIN) begin
            estado      <= ESPERA;
            cs_n        <= 1'b1;
            espera_cnt  <= '0;
            dato        <= trama[N_DATOS-1:0];
            err_trama   <= |trama[N_TRAMA-1 -: N_CEROS];
            dato_valido <= 1'b1;
          end
        end
        ESPERA: begin
          if (fase == 2'd3) begin
            if (espera_cnt == ESPERA_FIN) begin
              if (inicio) begin
                estado  <= CONVIERTE;
                cs_n    <= 1'b0;
                bit_cnt <= '0;
              end else begin
                estado <= REPOSO;
              end
            end else begin
              espera_cnt <= espera_cnt + ESPERA_W'(1);
            end
          end
        end
        default: begin
          estado <= REPOSO;
          cs_n   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_captura_serial.sv
// Scoreboard bench: an ADC model shifts frames out on sclk, expected samples are
// queued when a frame completes, and a monitor checks every dato_valido strobe.
module tb_adc_captura_serial;
  import adc_pkg::*;

  logic               clk_reloj = 1'b0;
  logic               rst_reset = 1'b1;
  logic [1:0]         fase = 2'd0;
  logic               inicio = 1'b0;
  logic               sdata = 1'b0;
  logic               cs_n;
  logic               sclk;
  logic [N_DATOS-1:0] dato;
  logic               dato_valido;
  logic               err_trama;
  logic               ocupado;

  adc_captura_serial dut (
    .clk_reloj   (clk_reloj),
    .rst_reset   (rst_reset),
    .fase        (fase),
    .inicio      (inicio),
    .sdata       (sdata),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .dato        (dato),
    .dato_valido (dato_valido),
    .err_trama   (err_trama),
    .ocupado     (ocupado)
  );

  always #5 clk_reloj = ~clk_reloj;

  // Free-running phase counter, deliberately not tied to the DUT reset.
  always @(posedge clk_reloj) fase <= fase + 2'd1;

  int cyc = 0;
  always @(posedge clk_reloj) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC model and reference: frame word -> {12-bit sample, any leading bit set}
  typedef struct {
    logic [11:0] d;
    logic        e;
  } exp_t;

  logic [15:0] frames_q[$];
  exp_t        exp_q[$];
  logic [15:0] palabra;
  logic [15:0] cur;
  int          nbits = 0;
  bit          in_frame = 1'b0;

  always @(negedge sclk) begin
    if (cs_n === 1'b0) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        nbits    = 0;
        palabra  = (frames_q.size() > 0) ? frames_q.pop_front() : 16'h0000;
        cur      = palabra;
      end
      sdata = cur[15];
      cur   = cur << 1;
      nbits++;
      if (nbits == 16) begin
        exp_t e;
        e.d = 12'(palabra % 4096);
        e.e = (palabra / 4096) != 0;
        exp_q.push_back(e);
      end
    end
  end

  always @(posedge cs_n) in_frame = 1'b0;

  // Monitor
  logic prev_cs  = 1'b1;
  logic prev_val = 1'b0;
  int   fall_cyc = -1000;
  int   rise_cyc = 0;
  int   last_high = 0;
  int   n_falls = 0;
  int   n_strobes = 0;
  int   last_strobe_cyc = 0;
  exp_t em;

  always @(negedge clk_reloj) begin
    if (rst_reset === 1'b0) begin
      if (prev_cs === 1'b1 && cs_n === 1'b0) begin
        n_falls++;
        last_high = cyc - rise_cyc;
        fall_cyc  = cyc;
      end
      if (prev_cs === 1'b0 && cs_n === 1'b1) rise_cyc = cyc;
      if (dato_valido === 1'b1) begin
        n_strobes++;
        last_strobe_cyc = cyc;
        check("valid_one_cycle", prev_val, 1'b0);
        check("strobe_latency", cyc - fall_cyc, 64);
        check("cs_n_at_strobe", cs_n, 1'b1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got dato %0h expected no strobe (cycle %0d)", dato, cyc);
        end else begin
          em = exp_q.pop_front();
          check("dato", dato, em.d);
          check("err_trama", err_trama, em.e);
        end
      end
    end else begin
      rise_cyc = cyc;
    end
    prev_cs  = cs_n;
    prev_val = dato_valido;
  end

  task automatic step();
    @(negedge clk_reloj);
    #1;
  endtask

  task automatic wait_fase3();
    int k = 0;
    while (fase != 2'd3 && k < 8) begin
      step();
      k++;
    end
  endtask

  task automatic wait_strobe(input int budget);
    int s0 = n_strobes;
    int k = 0;
    while (n_strobes == s0 && k < budget) begin
      step();
      k++;
    end
    if (n_strobes == s0) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_timeout: got no strobe expected one within %0d clk", budget);
    end
  endtask

  task automatic wait_fall(input int budget);
    int f0 = n_falls;
    int k = 0;
    while (n_falls == f0 && k < budget) begin
      step();
      k++;
    end
    if (n_falls == f0) begin
      n_checks++;
      n_fail++;
      $display("FAIL cs_fall_timeout: got no cs_n fall expected one within %0d clk", budget);
    end
  endtask

  task automatic wait_until(input int target);
    int k = 0;
    while (cyc < target && k < 200) begin
      step();
      k++;
    end
  endtask

  task automatic back_to_reposo();
    for (int i = 0; i < 3; i++) begin
      step();
      check("espera_ocupado", ocupado, 1'b1);
      check("espera_cs_n", cs_n, 1'b1);
    end
    step();
    check("reposo_ocupado", ocupado, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  int          c, f, s1, s2, s3, nf, ns;
  logic [15:0] w;

  initial begin
    // Reset held with fase running
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_sclk", sclk, 1'b1);
      check("rst_dato", dato, 12'h000);
      check("rst_valido", dato_valido, 1'b0);
      check("rst_ocupado", ocupado, 1'b0);
      check("rst_err", err_trama, 1'b0);
    end
    rst_reset = 1'b0;
    step();

    // Single pulsed conversion
    frames_q.push_back(16'h0A5C);
    wait_fase3();
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    wait_strobe(100);
    back_to_reposo();

    // Continuous mode
    frames_q.push_back(16'h0000);
    frames_q.push_back(16'h0FFF);
    frames_q.push_back(16'h0800);
    inicio = 1'b1;
    wait_strobe(100);
    s1 = last_strobe_cyc;
    wait_strobe(100);
    s2 = last_strobe_cyc;
    check("period_1_2", s2 - s1, 68);
    check("cs_high_len_2", last_high, 4);
    wait_strobe(100);
    s3 = last_strobe_cyc;
    inicio = 1'b0;
    check("period_2_3", s3 - s2, 68);
    check("cs_high_len_3", last_high, 4);
    back_to_reposo();

    // Random frames, random request phase
    for (int r = 0; r < 4; r++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[15:12] = 4'h0;
      frames_q.push_back(w);
      repeat ($urandom_range(0, 7)) step();
      c = cyc;
      f = int'(fase);
      inicio = 1'b1;
      wait_fall(10);
      inicio = 1'b0;
      check("start_delay", fall_cyc - c, ((3 - f) & 3) + 1);
      wait_strobe(100);
      back_to_reposo();
    end

    // Frame error, then a clean frame clears it
    frames_q.push_back(16'h4123);
    frames_q.push_back(16'h0123);
    inicio = 1'b1;
    wait_strobe(100);
    step();
    step();
    check("err_held", err_trama, 1'b1);
    wait_strobe(100);
    inicio = 1'b0;
    back_to_reposo();

    // Asynchronous reset mid-frame, after bit 7
    frames_q.push_back(16'h0777);
    inicio = 1'b1;
    wait_fall(10);
    c = fall_cyc;
    wait_until(c + 28);
    ns = n_strobes;
    #2;
    rst_reset = 1'b1;
    #1;
    check("arst_cs_n", cs_n, 1'b1);
    check("arst_sclk", sclk, 1'b1);
    check("arst_ocupado", ocupado, 1'b0);
    check("arst_valido", dato_valido, 1'b0);
    check("arst_dato", dato, 12'h000);
    check("arst_err", err_trama, 1'b0);
    frames_q.push_back(16'h0ABC);
    step();
    step();
    check("arst_no_strobe", n_strobes, ns);
    rst_reset = 1'b0;
    wait_strobe(120);
    inicio = 1'b0;
    back_to_reposo();

    // inicio dropped mid-frame
    frames_q.push_back(16'h0321);
    inicio = 1'b1;
    wait_fall(10);
    wait_until(fall_cyc + 17);
    inicio = 1'b0;
    wait_strobe(100);
    nf = n_falls;
    back_to_reposo();
    repeat (100) step();
    check("no_more_frames", n_falls, nf);

    check("exp_q_empty", exp_q.size(), 0);
    check("frames_q_empty", frames_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
